uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter for the same serial link the receiver consumes. It serialises one frame per accepted word: a start bit, data bits LSB first, an optional parity bit, then stop bits. Bit timing comes from the shared baud/phase counter. The block pulses phase_arm at the start of each frame to realign that counter. A one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
FRAME_BITS, 8, data bits per frame (>=2); bit index width is clog2(FRAME_BITS).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
bit_tick  input  1  one-cycle pulse at each bit boundary from the baud/phase counter; the first tick arrives one bit period after phase_arm
tx_valid  input  1  source presents a word on tx_data
tx_data  input  FRAME_BITS  word to send; must stay stable while tx_valid=1 and tx_ready=0
tx_ready  output  1  equals ~hold_full; a transfer occurs when tx_valid && tx_ready at a clk edge
tx  output  1  registered serial line; idles high
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on the final stop-bit tick of each frame
phase_arm  output  1  one-cycle pulse; restarts the baud/phase counter at frame start

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: tx=1, tx_ready=1 (hold empty), busy=0, done=0, phase_arm=0, state=IDLE, bit index=0, shifter=0.
- Reset mid-frame: at the next edge tx returns to 1, the holding register is discarded, and no done pulse is generated.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - bit_tick is ignored.
  - On an accept, load the shifter directly (holding register untouched). At the same edge: state<=START, tx<=0, phase_arm<=1.
  - tx is therefore low on the cycle after the accept.
- START: hold tx=0. On bit_tick: state<=DATA, tx<=shifter[0], bit index=0.
- DATA:
  - On each bit_tick, advance: tx<=next data bit, LSB first.
  - On the tick that ends bit FRAME_BITS-1: go to PARITY if enabled, else STOP with tx<=1.
- STOP:
  - tx=1 for STOP_BITS ticks, using a stop counter.
  - On the final stop tick: done<=1, then:
    - hold full: load the shifter from hold, clear hold, state<=START, tx<=0, phase_arm<=1. There is no idle bit; tx_ready rises the next cycle.
    - hold empty and tx_valid && tx_ready this same cycle: the word goes straight to the shifter and chains exactly as above.
    - otherwise: state<=IDLE, tx stays 1.
- Accept while busy (state != IDLE): the word goes into hold, hold_full<=1, tx_ready falls on the next cycle.
- tx_valid while tx_ready=0: ignored; the source must hold tx_valid and tx_data.
- bit_tick and accept in the same cycle: each is handled per the rules above; they never conflict.
- done and phase_arm never last more than 1 cycle.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: after the last data bit, enter PARITY. tx is the even-parity bit (XOR of all data bits) for one tick, then STOP. Frame length is 1+FRAME_BITS+1+STOP_BITS bit periods.
- Undefined: the PARITY state and logic are absent; DATA goes directly to STOP. Frame length is 1+FRAME_BITS+STOP_BITS.

Test Plan:
1. Reset, bit_tick every 16 cycles after phase_arm, send 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles; exactly one done pulse; busy=0 afterwards; tx_ready stays 1 throughout.
2. Send 0x00, then present 0xFF while busy -> tx_ready low until the first frame's stop tick; tx = 0, eight 0s, 1, then immediately 0, eight 1s, 1; two done pulses; a second phase_arm pulse coincides with the second start bit.
3. Hold empty, assert tx_valid with 0x3C exactly on the final stop tick of the preceding frame -> second start bit begins the next cycle with no idle bit; data bits 0,0,1,1,1,1,0,0.
4. Assert reset during data bit 3 of 0x55 with a word queued in hold -> next cycle: tx=1, busy=0, tx_ready=1, no done pulse; the queued word is never sent.
5. With UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 between data and stop (11 bit periods); send 0x03 -> parity bit 0. Without the macro: 10 bit periods.
6. STOP_BITS=2, send 0x81 then 0x01 back-to-back -> two stop-bit periods of tx=1 between the frames; done pulses only at the end of the second stop bit of each frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
// Word handshake between a data source and the UART transmitter.
//
// Signals:
//   tx_valid  source -> uart_tx  a word is presented on tx_data
//   tx_data   source -> uart_tx  word to send; held stable until accepted
//   tx_ready  uart_tx -> source  holding register empty; a transfer happens
//                                on a clk edge where tx_valid && tx_ready
//
// Modports: master (the source), slave (the transmitter).
// ---------------------------------------------------------------------------
interface uart_tx_if #(
  parameter int FRAME_BITS = 8
);

  logic                  tx_valid;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter. Each accepted word is sent as a start bit, FRAME_BITS
// data bits LSB first, an optional even-parity bit and STOP_BITS stop bits.
// Bit timing comes from an external baud/phase counter (bit_tick); this block
// pulses phase_arm at every frame start so that counter realigns. A one-entry
// holding register lets the next frame start with no idle bit.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   bit_tick   one-cycle pulse at each bit boundary
//   host       uart_tx_if.slave: tx_valid / tx_data in, tx_ready out
//   tx         registered serial line, idles high
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse on the final stop-bit tick of a frame
//   phase_arm  one-cycle pulse at frame start, restarts the baud counter
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bits.
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int FRAME_BITS = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     bit_tick,
  uart_tx_if.slave host,
  output logic     tx,
  output logic     busy,
  output logic     done,
  output logic     phase_arm
);

  localparam int              IDX_W     = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BITS - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state, state_next;
  logic                  tx_next, done_next, arm_next;
  logic [IDX_W-1:0]      bit_idx, bit_idx_next;
  logic [FRAME_BITS-1:0] shifter, shifter_next;
  logic [FRAME_BITS-1:0] hold_data, hold_data_next;
  logic                  hold_full, hold_full_next;
  logic [1:0]            stop_cnt, stop_cnt_next;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit, parity_next;
`endif
  logic                  accept;

  assign host.tx_ready = ~hold_full;
  assign accept        = host.tx_valid && host.tx_ready;
  assign busy          = (state != IDLE);

  // Next-state and next-output logic. Every register has a "hold" default so
  // each branch only spells out what changes. A word accepted while a frame
  // is in flight lands in the holding register, except on the final stop
  // tick with the hold empty, where it is chained straight into the shifter.
  // The parity bit is accumulated as each data bit goes onto the wire, since
  // the shifter no longer holds the whole word by the time it is needed.
  always_comb begin
    state_next     = state;
    tx_next        = tx;
    done_next      = 1'b0;
    arm_next       = 1'b0;
    bit_idx_next   = bit_idx;
    shifter_next   = shifter;
    hold_data_next = hold_data;
    hold_full_next = hold_full;
    stop_cnt_next  = stop_cnt;
`ifdef UART_TX_PARITY_EN
    parity_next    = parity_bit;
`endif

    if (accept && (state != IDLE)) begin
      hold_data_next = host.tx_data;
      hold_full_next = 1'b1;
    end

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          shifter_next = host.tx_data;
          state_next   = START;
          tx_next      = 1'b0;
          arm_next     = 1'b1;
        end
      end

      START: begin
        tx_next = 1'b0;
        if (bit_tick) begin
          state_next   = DATA;
          tx_next      = shifter[0];
          shifter_next = shifter >> 1;
          bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
          parity_next  = shifter[0];
`endif
        end
      end

      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_next    = PARITY;
            tx_next       = parity_bit;
`else
            state_next    = STOP;
            tx_next       = 1'b1;
            stop_cnt_next = 2'd0;
`endif
          end else begin
            tx_next      = shifter[0];
            shifter_next = shifter >> 1;
            bit_idx_next = bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_next  = parity_bit ^ shifter[0];
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_next    = STOP;
          tx_next       = 1'b1;
          stop_cnt_next = 2'd0;
        end
      end
`endif

      STOP: begin
        tx_next = 1'b1;
        if (bit_tick) begin
          if (stop_cnt == LAST_STOP) begin
            done_next = 1'b1;
            if (hold_full) begin
              shifter_next   = hold_data;
              hold_full_next = 1'b0;
              state_next     = START;
              tx_next        = 1'b0;
              arm_next       = 1'b1;
            end else if (accept) begin
              shifter_next   = host.tx_data;
              hold_full_next = 1'b0;
              state_next     = START;
              tx_next        = 1'b0;
              arm_next       = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            stop_cnt_next = stop_cnt + 2'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // State and output registers. Reset drops any frame in flight and empties
  // the holding register, so a queued word is discarded rather than sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      done       <= 1'b0;
      phase_arm  <= 1'b0;
      bit_idx    <= '0;
      shifter    <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      stop_cnt   <= 2'd0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      tx         <= tx_next;
      done       <= done_next;
      phase_arm  <= arm_next;
      bit_idx    <= bit_idx_next;
      shifter    <= shifter_next;
      hold_data  <= hold_data_next;
      hold_full  <= hold_full_next;
      stop_cnt   <= stop_cnt_next;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. A scoreboard queue receives the expected
// line bits of every frame when its word is handed to the DUT; a monitor
// samples tx in the middle of each bit period and pops/compares. Scenario
// tasks check timing (frame length, done/phase_arm/tx_ready behaviour).
// A second instance with STOP_BITS=2 covers the two-stop-bit case.
// ---------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FP1 = 1 + 8 + PAR_BITS + 1;
  localparam int FP2 = 1 + 8 + PAR_BITS + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_tick, tx, busy, done, phase_arm;
  logic bit_tick2, tx2, busy2, done2, phase_arm2;

  int checks = 0;
  int passes = 0;
  logic exp_q[$];

  uart_tx_if #(.FRAME_BITS(8)) bus ();
  uart_tx_if #(.FRAME_BITS(8)) bus2 ();

  uart_tx #(.FRAME_BITS(8), .STOP_BITS(1)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bit_tick  (bit_tick),
    .host      (bus),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .phase_arm (phase_arm)
  );

  uart_tx #(.FRAME_BITS(8), .STOP_BITS(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .bit_tick  (bit_tick2),
    .host      (bus2),
    .tx        (tx2),
    .busy      (busy2),
    .done      (done2),
    .phase_arm (phase_arm2)
  );

  always #5 clk = ~clk;

  // Baud/phase counter models: 16 cycles per bit, restarted by phase_arm so
  // the first tick lands one bit period after the arm pulse.
  logic [3:0] baud_cnt = 4'd0;
  logic [3:0] baud_cnt2 = 4'd0;

  always @(posedge clk) begin
    if (phase_arm) baud_cnt <= 4'd1;
    else           baud_cnt <= baud_cnt + 4'd1;
    if (phase_arm2) baud_cnt2 <= 4'd1;
    else            baud_cnt2 <= baud_cnt2 + 4'd1;
  end

  assign bit_tick  = (baud_cnt == 4'd15) && !phase_arm;
  assign bit_tick2 = (baud_cnt2 == 4'd15) && !phase_arm2;

  // Expected line level of bit period k of the frame carrying word.
  function automatic logic frame_bit(input logic [7:0] word, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return word[k-1];
    if (PAR_BITS == 1 && k == 9) return ^word;
    return 1'b1;
  endfunction

  task automatic push_frame(input logic [7:0] word);
    for (int k = 0; k < FP1; k++) exp_q.push_back(frame_bit(word, k));
  endtask

  // Mid-bit monitor for the single-stop instance.
  logic exp_bit;
  always @(negedge clk) begin
    if (!reset && busy && !phase_arm && baud_cnt == 4'd8) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL scoreboard_extra_bit tx=%b want no bit", tx);
      end else begin
        exp_bit = exp_q.pop_front();
        if (tx !== exp_bit) $display("[TB] FAIL scoreboard_bit got=%b want=%b", tx, exp_bit);
        else passes++;
      end
    end
  end

  // Present a word at a negedge and hold it until accepted; returns at the
  // negedge after the accepting edge with tx_valid dropped.
  task automatic applyStimulus(input logic [7:0] word, input bit expect_sent);
    int waited = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = word;
    while (bus.tx_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.tx_ready !== 1'b1) $display("[TB] FAIL accept_timeout ready=%b want=1", bus.tx_ready);
    else passes++;
    if (expect_sent) push_frame(word);
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tx !== 1'b1) $display("[TB] FAIL reset_tx got=%b want=1", tx); else passes++;
    checks++; if (bus.tx_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b want=1", bus.tx_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got=%b want=0", done); else passes++;
    checks++; if (phase_arm !== 1'b0) $display("[TB] FAIL reset_arm got=%b want=0", phase_arm); else passes++;
    checks++; if (tx2 !== 1'b1) $display("[TB] FAIL reset_tx2 got=%b want=1", tx2); else passes++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single;
    int cyc = 0;
    bit ready_drop = 1'b0;
    applyStimulus(8'hA5, 1'b1);
    checks++; if (phase_arm !== 1'b1) $display("[TB] FAIL single_arm got=%b want=1", phase_arm); else passes++;
    checks++; if (tx !== 1'b0) $display("[TB] FAIL single_start got=%b want=0", tx); else passes++;
    while (done !== 1'b1 && cyc < 3000) begin
      if (bus.tx_ready !== 1'b1) ready_drop = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc != FP1 * 16) $display("[TB] FAIL single_len got=%0d want=%0d", cyc, FP1 * 16); else passes++;
    checks++; if (ready_drop) $display("[TB] FAIL single_ready dropped=1 want=0"); else passes++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("[TB] FAIL single_done_width got=%b want=0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_after got=%b want=0", busy); else passes++;
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL single_drain left=%0d want=0", exp_q.size()); else passes++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    bit ready_early = 1'b0;
    applyStimulus(8'h00, 1'b1);
    repeat (19) @(negedge clk);
    applyStimulus(8'hFF, 1'b1);
    checks++; if (bus.tx_ready !== 1'b0) $display("[TB] FAIL b2b_ready_low got=%b want=0", bus.tx_ready); else passes++;
    while (done !== 1'b1 && cyc < 3000) begin
      if (bus.tx_ready !== 1'b0) ready_early = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++; if (20 + cyc != FP1 * 16) $display("[TB] FAIL b2b_len1 got=%0d want=%0d", 20 + cyc, FP1 * 16); else passes++;
    checks++; if (ready_early) $display("[TB] FAIL b2b_ready_early got=1 want=0"); else passes++;
    checks++; if (bus.tx_ready !== 1'b1) $display("[TB] FAIL b2b_ready_rise got=%b want=1", bus.tx_ready); else passes++;
    checks++; if (phase_arm !== 1'b1) $display("[TB] FAIL b2b_arm2 got=%b want=1", phase_arm); else passes++;
    checks++; if (tx !== 1'b0) $display("[TB] FAIL b2b_no_gap got=%b want=0", tx); else passes++;
    @(negedge clk);
    wait_done(cyc);
    checks++; if (cyc + 1 != FP1 * 16) $display("[TB] FAIL b2b_len2 got=%0d want=%0d", cyc + 1, FP1 * 16); else passes++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_busy_after got=%b want=0", busy); else passes++;
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL b2b_drain left=%0d want=0", exp_q.size()); else passes++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_chain_on_stop;
    int cyc;
    applyStimulus(8'h5A, 1'b1);
    repeat (FP1 * 16 - 1) @(negedge clk);
    checks++; if (bus.tx_ready !== 1'b1) $display("[TB] FAIL chain_ready got=%b want=1", bus.tx_ready); else passes++;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h3C;
    push_frame(8'h3C);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    checks++; if (done !== 1'b1) $display("[TB] FAIL chain_done got=%b want=1", done); else passes++;
    checks++; if (phase_arm !== 1'b1) $display("[TB] FAIL chain_arm got=%b want=1", phase_arm); else passes++;
    checks++; if (tx !== 1'b0) $display("[TB] FAIL chain_start got=%b want=0", tx); else passes++;
    checks++; if (bus.tx_ready !== 1'b1) $display("[TB] FAIL chain_hold_unused got=%b want=1", bus.tx_ready); else passes++;
    @(negedge clk);
    wait_done(cyc);
    checks++; if (cyc + 1 != FP1 * 16) $display("[TB] FAIL chain_len got=%0d want=%0d", cyc + 1, FP1 * 16); else passes++;
    @(negedge clk);
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL chain_drain left=%0d want=0", exp_q.size()); else passes++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    bit saw_done = 1'b0;
    bit saw_low  = 1'b0;
    applyStimulus(8'h55, 1'b1);
    repeat (9) @(negedge clk);
    applyStimulus(8'h12, 1'b0);
    checks++; if (bus.tx_ready !== 1'b0) $display("[TB] FAIL rst_hold_full got=%b want=0", bus.tx_ready); else passes++;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) $display("[TB] FAIL rst_mid_tx got=%b want=1", tx); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy got=%b want=0", busy); else passes++;
    checks++; if (bus.tx_ready !== 1'b1) $display("[TB] FAIL rst_mid_ready got=%b want=1", bus.tx_ready); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL rst_mid_done got=%b want=0", done); else passes++;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      if (tx !== 1'b1) saw_low = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_done) $display("[TB] FAIL rst_no_done got=1 want=0"); else passes++;
    checks++; if (saw_low) $display("[TB] FAIL rst_queued_dropped tx_low=1 want=0"); else passes++;
  endtask

  task automatic test_parity;
    int cyc;
    logic [7:0] words [2];
    words[0] = 8'h07;
    words[1] = 8'h03;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(words[i], 1'b1);
      wait_done(cyc);
      checks++; if (cyc != FP1 * 16) $display("[TB] FAIL parity_len word=%h got=%0d want=%0d", words[i], cyc, FP1 * 16); else passes++;
      repeat (6) @(negedge clk);
      checks++; if (exp_q.size() != 0) $display("[TB] FAIL parity_drain word=%h left=%0d want=0", words[i], exp_q.size()); else passes++;
    end
  endtask

  logic tx2_log [0:399];
  logic done2_log [0:399];

  task automatic test_two_stop;
    int per = FP2 * 16;
    int dones = 0;
    logic [7:0] word;
    bus2.tx_valid = 1'b1;
    bus2.tx_data  = 8'h81;
    checks++; if (bus2.tx_ready !== 1'b1) $display("[TB] FAIL stop2_ready got=%b want=1", bus2.tx_ready); else passes++;
    @(negedge clk);
    bus2.tx_valid = 1'b0;
    checks++; if (phase_arm2 !== 1'b1) $display("[TB] FAIL stop2_arm got=%b want=1", phase_arm2); else passes++;
    for (int c = 0; c < 2 * per + 16; c++) begin
      tx2_log[c]   = tx2;
      done2_log[c] = done2;
      if (c == 10) begin
        bus2.tx_valid = 1'b1;
        bus2.tx_data  = 8'h01;
      end
      if (c == 11) bus2.tx_valid = 1'b0;
      @(negedge clk);
    end
    for (int f = 0; f < 2; f++) begin
      word = (f == 0) ? 8'h81 : 8'h01;
      for (int k = 0; k < FP2; k++) begin
        checks++;
        if (tx2_log[f * per + 16 * k + 8] !== frame_bit(word, k))
          $display("[TB] FAIL stop2_bit frame=%0d k=%0d got=%b want=%b", f, k, tx2_log[f * per + 16 * k + 8], frame_bit(word, k));
        else passes++;
      end
    end
    for (int c = 0; c < 2 * per + 16; c++) if (done2_log[c] === 1'b1) dones++;
    checks++; if (dones != 2) $display("[TB] FAIL stop2_done_count got=%0d want=2", dones); else passes++;
    checks++; if (done2_log[per] !== 1'b1) $display("[TB] FAIL stop2_done1 got=%b want=1", done2_log[per]); else passes++;
    checks++; if (done2_log[2 * per] !== 1'b1) $display("[TB] FAIL stop2_done2 got=%b want=1", done2_log[2 * per]); else passes++;
    checks++; if (tx2_log[per] !== 1'b0) $display("[TB] FAIL stop2_chain_start got=%b want=0", tx2_log[per]); else passes++;
  endtask

  initial begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_chain_on_stop;
    test_reset_mid_frame;
    test_parity;
    test_two_stop;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
